// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between the fetch (i_*) and data (d_*) requesters, round-robin, with a watchdog.
// Latency: request seen in IDLE at cycle 0, mem_req during cycles 1..k, x_ack at cycle k+1 (zero-wait memory: ack at cycle 2).
// Backpressure: requesters hold req until their one-cycle ack; stall is high while any request is still unacknowledged.
//
// Ports:
//   clk, rst         - clock; asynchronous active-low reset
//   i_req/i_addr     - fetch request and address; i_rdata/i_ack return the word
//   d_req/d_we/...   - data request (d_we all-zero = read); d_rdata/d_ack return the result
//   mem_*            - single external memory port; mem_ack only counts while BUSY
//   stall            - pipeline stall; timeout_err is sticky once a watchdog abort happens
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall,
  output logic                timeout_err
);

  localparam logic [TO_W-1:0] TIMEOUT_VAL = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } state_t;

  state_t          state;
  logic            lastGrantI;  // 1: the most recent grant went to the fetch side
  logic [TO_W-1:0] wdCnt;       // BUSY cycles already completed for this access
  logic [TO_W-1:0] wdNext;
  logic            wdExpire;
  logic            grantD;

  // wdNext counts the current BUSY cycle, so an abort happens at the end of
  // BUSY cycle TIMEOUT. A same-cycle mem_ack is checked first and wins.
  assign wdNext   = wdCnt + TO_W'(1);
  assign wdExpire = (TIMEOUT != 0) && (wdNext == TIMEOUT_VAL);

  // On a tie the side that did not win last time is served.
  assign grantD = d_req && (!i_req || lastGrantI);

  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lastGrantI  <= 1'b1;
      wdCnt       <= '0;
      i_rdata     <= '0;
      i_ack       <= 1'b0;
      d_rdata     <= '0;
      d_ack       <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      mem_we      <= '0;
      mem_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grantD) begin
            state      <= BUSY_D;
            lastGrantI <= 1'b0;
            wdCnt      <= '0;
            mem_req    <= 1'b1;
            mem_addr   <= d_addr;
            mem_we     <= d_we;
            mem_wdata  <= d_wdata;
          end else if (i_req) begin
            state      <= BUSY_I;
            lastGrantI <= 1'b1;
            wdCnt      <= '0;
            mem_req    <= 1'b1;
            mem_addr   <= i_addr;
            mem_we     <= '0;
          end
        end

        BUSY_I, BUSY_D: begin
          if (mem_ack || wdExpire) begin
            mem_req <= 1'b0;
            mem_we  <= '0;
            if (state == BUSY_I) begin
              state <= DONE_I;
              i_ack <= 1'b1;
            end else begin
              state <= DONE_D;
              d_ack <= 1'b1;
            end
            // Aborted accesses leave the read data untouched; writes never update d_rdata.
            if (!mem_ack) begin
              timeout_err <= 1'b1;
            end else if (state == BUSY_I) begin
              i_rdata <= mem_rdata;
            end else if (mem_we == '0) begin
              d_rdata <= mem_rdata;
            end
          end else begin
            wdCnt <= wdNext;
          end
        end

        DONE_I, DONE_D: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one backing-memory port between the CPU instruction-fetch requester and data-access requester.
- Sequences each access with a req/ack handshake and generates the pipeline stall.
- Sits between the CPU core's icache/dcache-side signals and the single external memory port.
- Round-robin arbitration with a per-access watchdog timeout.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT, 255, maximum BUSY cycles before abort; 0 disables the watchdog.
- TO_W, 8, watchdog counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk in 1: single clock; all state changes on the rising edge.
- rst in 1: asynchronous, active-low reset; 0 resets all state immediately.
- i_req in 1: instruction fetch request; held until i_ack.
- i_addr in ADDR_W: fetch address.
- i_rdata out DATA_W: fetched word; valid while i_ack=1, held afterwards.
- i_ack out 1: one-cycle completion pulse for fetch.
- d_req in 1: data request; held until d_ack.
- d_we in DATA_W/8: byte write enables; all-zero means read.
- d_addr in ADDR_W: data address.
- d_wdata in DATA_W: write data.
- d_rdata out DATA_W: read data; valid while d_ack=1 after a read.
- d_ack out 1: one-cycle completion pulse for data.
- mem_req out 1: memory request; high throughout BUSY.
- mem_addr out ADDR_W: latched address.
- mem_we out DATA_W/8: latched enables; always 0 for fetch.
- mem_wdata out DATA_W: latched write data.
- mem_rdata in DATA_W: memory read data; sampled with mem_ack.
- mem_ack in 1: memory completion; counted only in BUSY.
- stall out 1: combinational (i_req&~i_ack)|(d_req&~d_ack).
- timeout_err out 1: sticky; set on any watchdog abort.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant=I, so the first tie goes to D.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE, no request: stay IDLE.
- IDLE, one request: go to BUSY of that requester.
- IDLE, both requests: grant the requester not equal to last_grant, then update last_grant.
- On grant: latch addr/we/wdata into the mem_* registers (we=0 for I); clear the watchdog counter.
- BUSY_x: mem_req=1, latched fields stable; watchdog increments each cycle.
- BUSY_x with mem_ack=1: capture mem_rdata into x_rdata (reads only; d_rdata unchanged on writes); go to DONE_x.
- BUSY_x, TIMEOUT≠0, counter reaches TIMEOUT with no ack:
  - go to DONE_x and set timeout_err; x_rdata unchanged;
  - an ack arriving in that same cycle wins (normal completion, no error).
- DONE_x: x_ack=1, mem_req=0, mem_we=0; next state is always IDLE.
- Latency: request seen in IDLE at cycle 0, mem_req cycles 1..k, x_ack at cycle k+1.
  - With a zero-wait memory (ack in cycle 1), ack comes at cycle 2.
  - Minimum 3 cycles between grants.
- Requester protocol:
  - may drop or change req only in the cycle after x_ack;
  - req dropped while BUSY is ignored (the access still completes).
- mem_ack in IDLE/DONE: ignored; no state change.
- Never both acks in one cycle; never mem_req while in DONE or IDLE.
- Reset mid-access: everything returns to reset values immediately.
  - Requesters must reissue.
  - A late mem_ack after reset is ignored because the FSM is in IDLE.

Test Plan:
- Single fetch, i_addr=0x1000, mem_ack in cycle 1 with rdata 0x2402000A -> mem_req cycle 1 only, i_ack cycle 2 with i_rdata=0x2402000A; stall=1 cycles 0–1, 0 cycle 2.
- Simultaneous i_req and d_req (read 0x2000) right after reset -> D granted first, then I.
  - Hold both requests for 4 transactions: grants alternate D,I,D,I.
- Data write, d_we=4'b0011, d_wdata=0xCAFEF00D, 3-wait memory:
  - mem_we=0011 and mem_wdata stable for cycles 1–4, d_ack cycle 5, d_rdata unchanged.
- TIMEOUT=4, memory never acks -> mem_req cycles 1–4, d_ack cycle 5, timeout_err=1 and stays set.
  - A following normal access completes correctly with timeout_err still 1.
- rst pulled low in BUSY_I cycle 2, released cycle 4, mem_ack arrives cycle 5:
  - all outputs 0 during reset; late ack ignored with no i_ack;
  - a new i_req is served normally.
- Spurious mem_ack while IDLE with no requests -> no ack outputs, no state change, stall=0.
